// File: rtl/piso_4_bits_tx_pkg.sv
// ============================================================================
// Module : piso_pkg
// Brief  : State encoding and default parameters for the PISO transmitter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_GAP       = 1;
  localparam bit DEF_MSB_FIRST = 1'b0;

endpackage

`default_nettype wire

// File: rtl/piso_4_bits_tx_if.sv
// ============================================================================
// Module : piso_4_bits_tx_if
// Brief  : Valid/ready word handshake between upstream and the transmitter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface piso_4_bits_tx_if #(
  parameter int WIDTH = 4
) ();

  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );

endinterface

`default_nettype wire

// File: rtl/piso_4_bits_tx_shift.sv
// ============================================================================
// Module : piso_4_bits_tx_shift
// Brief  : Parallel-load shift register; bit order selected by MSB_FIRST.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module piso_4_bits_tx_shift #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic             shift,
  input  wire logic [WIDTH-1:0] load_data,
  output logic                  first_bit,
  output logic                  next_bit
);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shifted;

  // first_bit comes straight from load_data so the first bit can be
  // registered on the accepting edge; next_bit is the one after the current.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign first_bit = load_data[WIDTH-1];
      assign next_bit  = r_shift[WIDTH-2];
      assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign first_bit = load_data[0];
      assign next_bit  = r_shift[1];
      assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
    end else if (load) begin
      r_shift <= load_data;
    end else if (shift) begin
      r_shift <= w_shifted;
    end
  end

endmodule

`default_nettype wire

// File: rtl/piso_4_bits_tx.sv
// ============================================================================
// Module : piso_4_bits_tx
// Brief  : Handshaked word in, one framed serial bit per clock out with enable.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module piso_4_bits_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = DEF_MSB_FIRST,
  parameter int GAP       = DEF_GAP
) (
  input  wire logic           clk,
  input  wire logic           rst,
  piso_4_bits_tx_if.slave     bus,
  output logic                D,
  output logic                en,
  output logic                busy,
  output logic                done
);

  localparam int                c_cnt_w    = $clog2(WIDTH) + 1;
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);
  localparam logic [3:0]         c_gap_last = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t               r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]           r_gap, w_gap_nxt;
  logic                 r_d, w_d_nxt;
  logic                 r_en, w_en_nxt;
  logic                 r_ready, w_ready_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;

  logic                 w_accept;
  logic                 w_shift;
  logic                 w_first_bit;
  logic                 w_next_bit;

  assign w_accept = bus.valid_in & r_ready;
  assign w_shift  = (r_state == ST_SHIFT) && (r_cnt != c_last);

  piso_4_bits_tx_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (w_accept),
    .shift     (w_shift),
    .load_data (bus.data_in),
    .first_bit (w_first_bit),
    .next_bit  (w_next_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_d     <= 1'b0;
      r_en    <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      r_d     <= w_d_nxt;
      r_en    <= w_en_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Every output is computed one cycle ahead so it can leave a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_d_nxt     = 1'b0;
    w_en_nxt    = 1'b0;
    w_ready_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_ready_nxt = 1'b1;
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = '0;
          w_d_nxt     = w_first_bit;
          w_en_nxt    = 1'b1;
          w_ready_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == c_last) begin
          w_done_nxt = 1'b1;
          if (GAP > 0) begin
            w_state_nxt = ST_GAP;
            w_gap_nxt   = '0;
            w_busy_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_ready_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt  = r_cnt + 1'b1;
          w_d_nxt    = w_next_bit;
          w_en_nxt   = 1'b1;
          w_busy_nxt = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gap == c_gap_last) begin
          w_state_nxt = ST_IDLE;
          w_ready_nxt = 1'b1;
        end else begin
          w_gap_nxt  = r_gap + 1'b1;
          w_busy_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  assign bus.ready_out = r_ready;
  assign D             = r_d;
  assign en            = r_en;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_piso_4_bits_tx.sv
// ============================================================================
// Module : tb_piso_4_bits_tx
// Brief  : Self-checking bench: LSB-first/GAP=1 and MSB-first/GAP=0 instances.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_piso_4_bits_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d0, en0, busy0, done0;
  logic d1, en1, busy1, done1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] tr_en, tr_d, tr_done, tr_rdy, tr_busy;

  always #5 clk = ~clk;

  piso_4_bits_tx_if #(.WIDTH(4)) bus0 ();
  piso_4_bits_tx_if #(.WIDTH(4)) bus1 ();

  piso_4_bits_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP(1)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0),
    .D (d0), .en (en0), .busy (busy0), .done (done0)
  );

  piso_4_bits_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(0)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1),
    .D (d1), .en (en1), .busy (busy1), .done (done1)
  );

  typedef struct {
    int         sel;
    logic [3:0] data;
    logic [3:0] exp_stream;  // transmitted bits, first bit leftmost
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs at a falling edge, let one rising edge pass, record outputs.
  task automatic step(input int sel, input logic v, input logic [3:0] d, input logic r);
    rst = r;
    if (sel == 0) begin
      bus0.valid_in = v;
      bus0.data_in  = d;
    end else begin
      bus1.valid_in = v;
      bus1.data_in  = d;
    end
    @(negedge clk);
    if (sel == 0) begin
      tr_en   = {tr_en[14:0], en0};
      tr_d    = {tr_d[14:0], d0};
      tr_done = {tr_done[14:0], done0};
      tr_rdy  = {tr_rdy[14:0], bus0.ready_out};
      tr_busy = {tr_busy[14:0], busy0};
    end else begin
      tr_en   = {tr_en[14:0], en1};
      tr_d    = {tr_d[14:0], d1};
      tr_done = {tr_done[14:0], done1};
      tr_rdy  = {tr_rdy[14:0], bus1.ready_out};
      tr_busy = {tr_busy[14:0], busy1};
    end
  endtask

  task automatic clear_trace();
    tr_en = '0; tr_d = '0; tr_done = '0; tr_rdy = '0; tr_busy = '0;
  endtask

  // Reference: bit k of the frame in time order.
  function automatic logic [3:0] model_stream(input int sel, input logic [3:0] data);
    logic [3:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      s = {s[2:0], data[(sel == 1) ? (3 - k) : k]};
    end
    return s;
  endfunction

  // Send one word, trace 8 cycles, and compare against the expected frame.
  task automatic frame(input string name, input int sel, input logic [3:0] data,
                       input logic [3:0] exp_stream);
    logic [3:0] stream, word;
    int         waited;
    logic       rdy;
    waited = 0;
    rdy = (sel == 0) ? bus0.ready_out : bus1.ready_out;
    while (!rdy && waited < 40) begin
      step(sel, 1'b0, 4'h0, 1'b0);
      waited++;
      rdy = (sel == 0) ? bus0.ready_out : bus1.ready_out;
    end
    check({name, "_ready_timeout"}, 32'(rdy), 32'd1);
    clear_trace();
    step(sel, 1'b1, data, 1'b0);
    for (int i = 0; i < 7; i++) step(sel, 1'b0, ~data, 1'b0);
    stream = '0;
    word   = '0;
    for (int i = 7; i >= 0; i--) begin
      if (tr_en[i]) begin
        stream = {stream[2:0], tr_d[i]};
        // downstream 4-bit SIPO, shifting so the word lands in natural order
        if (sel == 1) word = {word[2:0], tr_d[i]};
        else          word = {tr_d[i], word[3:1]};
      end
    end
    check({name, "_en"},     32'(tr_en[7:0]),   32'b11110000);
    check({name, "_done"},   32'(tr_done[7:0]), 32'b00001000);
    check({name, "_stream"}, 32'(stream),       32'(exp_stream));
    check({name, "_word"},   32'(word),         32'(data));
  endtask

  vec_t vecs[6];

  initial begin
    bus0.valid_in = 1'b0; bus0.data_in = 4'h0;
    bus1.valid_in = 1'b0; bus1.data_in = 4'h0;
    clear_trace();
    repeat (3) @(negedge clk);

    check("rst_ready0", 32'(bus0.ready_out), 32'd1);
    check("rst_en0",    32'(en0),            32'd0);
    check("rst_d0",     32'(d0),             32'd0);
    check("rst_busy0",  32'(busy0),          32'd0);
    check("rst_done0",  32'(done0),          32'd0);
    check("rst_ready1", 32'(bus1.ready_out), 32'd1);
    check("rst_en1",    32'(en1),            32'd0);
    check("rst_busy1",  32'(busy1),          32'd0);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{0, 4'b0100, 4'b0010};
    vecs[1] = '{1, 4'b1101, 4'b1101};
    vecs[2] = '{0, 4'hA,    4'b0101};
    vecs[3] = '{1, 4'h3,    4'b0011};
    vecs[4] = '{0, 4'h8,    4'b0001};
    vecs[5] = '{1, 4'h8,    4'b1000};
    for (int i = 0; i < 6; i++) begin
      frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].data, vecs[i].exp_stream);
    end

    // Back-to-back words with valid held high, GAP=1.
    clear_trace();
    step(0, 1'b1, 4'hA, 1'b0);
    for (int i = 0; i < 6; i++) step(0, 1'b1, 4'h5, 1'b0);
    for (int i = 0; i < 7; i++) step(0, 1'b0, 4'h0, 1'b0);
    check("b2b_en",    32'(tr_en[13:0]),   32'b11110011110000);
    check("b2b_d",     32'(tr_d[13:0]),    32'b01010010100000);
    check("b2b_done",  32'(tr_done[13:0]), 32'b00001000001000);
    check("b2b_ready", 32'(tr_rdy[13:0]),  32'b00000100000111);
    check("b2b_busy",  32'(tr_busy[13:0]), 32'b11111011111000);

    // Valid pulsed mid-frame is ignored.
    clear_trace();
    step(0, 1'b1, 4'h3, 1'b0);
    step(0, 1'b0, 4'h3, 1'b0);
    step(0, 1'b1, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) step(0, 1'b0, 4'hF, 1'b0);
    check("ign_en",    32'(tr_en[7:0]),   32'b11110000);
    check("ign_d",     32'(tr_d[7:0]),    32'b11000000);
    check("ign_done",  32'(tr_done[7:0]), 32'b00001000);
    check("ign_ready", 32'(tr_rdy[7:0]),  32'b00000111);

    // Reset during the second bit cycle.
    clear_trace();
    step(0, 1'b1, 4'hF, 1'b0);
    step(0, 1'b0, 4'hF, 1'b0);
    step(0, 1'b0, 4'hF, 1'b1);
    step(0, 1'b0, 4'hF, 1'b0);
    step(0, 1'b0, 4'hF, 1'b0);
    check("rmid_en",    32'(tr_en[4:0]),   32'b11000);
    check("rmid_d",     32'(tr_d[4:0]),    32'b11000);
    check("rmid_done",  32'(tr_done[4:0]), 32'b00000);
    check("rmid_ready", 32'(tr_rdy[4:0]),  32'b00111);
    check("rmid_busy",  32'(tr_busy[4:0]), 32'b11000);

    // Reset together with valid: no frame until a later handshake.
    clear_trace();
    step(0, 1'b1, 4'hF, 1'b1);
    step(0, 1'b0, 4'hF, 1'b0);
    step(0, 1'b0, 4'hF, 1'b0);
    step(0, 1'b1, 4'h5, 1'b0);
    for (int i = 0; i < 7; i++) step(0, 1'b0, 4'h0, 1'b0);
    check("rv_en",   32'(tr_en[10:0]),   32'b00011110000);
    check("rv_d",    32'(tr_d[10:0]),    32'b00010100000);
    check("rv_done", 32'(tr_done[10:0]), 32'b00000001000);

    // Randomized words on either instance against the reference stream.
    for (int i = 0; i < 24; i++) begin
      int         sel;
      logic [3:0] data;
      sel  = int'($urandom_range(1, 0));
      data = 4'($urandom);
      frame($sformatf("rnd%0d_s%0d_%h", i, sel, data), sel, data, model_stream(sel, data));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/piso_4_bits_tx.md
Name: piso_4_bits_tx

Overview:
- Parallel-in serial-out transmitter that sits directly upstream of the 4-bit serial-in parallel-out shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Drives it out one bit per clock on a serial data line with a qualifying enable, so the downstream shift register captures exactly one frame.
- Provides busy/done status to the controlling logic.

Parameters:
- WIDTH, 4, bits per frame; legal range 2..16.
- MSB_FIRST, 0, 0 = bit 0 transmitted first, 1 = bit WIDTH-1 first.
- GAP, 1, idle cycles with en low inserted after each frame before ready returns; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  word to transmit; sampled only on an accepted handshake.
- valid_in  input  1  data_in is valid.
- ready_out  output  1  block can accept a word this cycle.
- D  output  1  serial data bit, feeds the shift register D input.
- en  output  1  shift enable, high exactly while D carries a frame bit.
- busy  output  1  high in SHIFT or GAP state.
- done  output  1  one-cycle pulse after the last bit of a frame has been presented.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- All outputs are registered; none has a combinational path from an input.
- Reset values: state=IDLE, ready_out=1, D=0, en=0, busy=0, done=0, shift register=0, bit counter=0.
- States:
  - IDLE: ready_out=1, en=0, D=0, busy=0.
  - SHIFT: ready_out=0, en=1, busy=1.
  - GAP: ready_out=0, en=0, D=0, busy=1.
- IDLE -> SHIFT on a rising edge with valid_in=1 and ready_out=1 (accept):
  - load data_in into the shift register; counter=0.
  - D takes the first bit (bit 0 if MSB_FIRST=0, else bit WIDTH-1) and en=1 in the cycle after the accepting edge. Latency accept -> first bit = 1 cycle.
- SHIFT, each edge:
  - shift the register toward the output bit; counter+1; D = next bit.
  - en stays high for exactly WIDTH consecutive cycles.
- SHIFT exit, at the edge ending the WIDTH-th bit cycle:
  - en=0, D=0, done=1 for exactly one cycle.
  - If GAP>0, go to GAP; else go to IDLE.
- GAP: counts GAP cycles, then goes to IDLE with ready_out=1.
- Throughput: one word per WIDTH+GAP+1 cycles. Min spacing between frames with GAP=0 is one IDLE cycle (en low).
- valid_in while ready_out=0: ignored; no queuing. The word is not captured; the upstream holds valid until it sees the handshake.
- data_in changes after accept have no effect on the frame in flight.
- rst asserted mid-frame: at that edge en=0, D=0, no done pulse, state IDLE. The partial frame is discarded.
- rst and valid_in together: reset wins; word not accepted.
- Counter width: clog2(WIDTH)+1 bits, no wrap during a frame. GAP counter is 4 bits.

Decomposition:
- Shared package piso_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2.
  - default WIDTH and GAP constants.
- Sub-module: none required. An optional shift_reg_load (parallel-load shift register, direction set by MSB_FIRST) keeps the FSM file small.

Test Plan:
- Reset then data_in=4'b0100, valid_in pulse (MSB_FIRST=0) -> ready_out low next cycle; D=0,0,1,0 with en=1 for exactly 4 cycles; done pulse on the 5th cycle; downstream shift register holds 0100 after the frame.
- MSB_FIRST=1, data_in=4'b1101 -> D=1,1,0,1 over 4 en cycles; done once.
- valid_in held high continuously with words 4'hA then 4'h5, GAP=1 -> frames separated by exactly 2 en-low cycles (1 GAP + 1 IDLE). Second word is accepted only when ready_out=1. Serial stream is 0,1,0,1 then 1,0,1,0.
- valid_in pulsed during SHIFT with 4'hF -> ignored; the in-flight frame 4'h3 is unchanged; no second frame is sent.
- rst asserted on the 2nd bit cycle of 4'b1111 -> next cycle en=0, D=0, ready_out=1, busy=0; no done pulse.
- rst held together with valid_in=1 -> no frame is started; en stays 0 after rst is released until a new handshake.
